// File: rtl/div_rep_sub.sv
// Unsigned sequential divider by repeated subtraction: one subtract per clock,
// start/busy/done handshake, divide-by-zero flagged alongside done.
module div_rep_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;
  logic             w_accept;
  logic             w_fits;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_fits   = (r_rem >= r_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!w_fits) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Results update only on acceptance (zero divisor) or at the end of RUN,
  // so they hold across IDLE until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else if (w_accept) begin
      r_rem      <= dividend;
      r_div      <= divisor;
      r_cnt      <= '0;
      r_div_zero <= (divisor == '0);
      if (divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
      end
    end else if (r_state == S_RUN) begin
      if (w_fits) begin
        r_rem <= r_rem - r_div;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_quotient  <= r_cnt;
        r_remainder <= r_rem;
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_div_rep_sub.sv
// Self-checking bench for div_rep_sub: directed cases plus random operands
// checked against plain integer division, latency and handshake rules.
module tb_div_rep_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  int compared   = 0;
  int mismatched = 0;

  div_rep_sub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one division and checks results, latency (edges from the accepting
  // edge until done is seen), busy throughout, one-cycle done and result hold.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input bit poke);
    int exp_q, exp_r, exp_dz, exp_lat, edges;
    bit busy_dropped;
    if (b == 16'd0) begin
      exp_q = 32'hFFFF; exp_r = a; exp_dz = 1; exp_lat = 0;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dz = 0; exp_lat = exp_q + 1;
    end
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    edges = 0;
    busy_dropped = 1'b0;
    while (!done && edges < 70000) begin
      if (!busy) busy_dropped = 1'b1;
      if (poke && edges == 100) begin
        start = 1'b1; dividend = 16'd7; divisor = 16'd7;
      end
      if (poke && edges == 103) start = 1'b0;
      @(negedge clk);
      edges++;
    end
    $display("div %0d/%0d -> q=%0d r=%0d dz=%0b after %0d cycles (expect q=%0d r=%0d dz=%0d lat=%0d)",
             a, b, quotient, remainder, div_zero, edges, exp_q, exp_r, exp_dz, exp_lat);
    check("done_seen", 32'(done), 32'd1);
    check("latency", edges, exp_lat);
    check("quotient", 32'(quotient), exp_q);
    check("remainder", 32'(remainder), exp_r);
    check("div_zero", 32'(div_zero), exp_dz);
    check("busy_in_done", 32'(busy), 32'd1);
    check("busy_held", 32'(busy_dropped), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    repeat (3) @(negedge clk);
    check("quotient_hold", 32'(quotient), exp_q);
    check("remainder_hold", 32'(remainder), exp_r);
  endtask

  initial begin
    int done_cnt;
    logic [15:0] ra, rb;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run_div(16'd100, 16'd7, 1'b0);
    run_div(16'd5, 16'd9, 1'b0);
    run_div(16'd0, 16'd3, 1'b0);
    run_div(16'd21, 16'd7, 1'b0);
    run_div(16'd1234, 16'd0, 1'b0);
    run_div(16'd65535, 16'd1, 1'b1);

    // Asynchronous reset in the middle of a long division.
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_quotient", 32'(quotient), 32'd0);
    check("arst_remainder", 32'(remainder), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    $display("reset abort: done pulses after abort = %0d", done_cnt);
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    run_div(16'd50, 16'd6, 1'b0);

    // Random operands; divisor raised when needed to keep the run short.
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      if (i % 8 == 0) rb = 16'd0;
      else if (rb != 16'd0 && (ra / rb) > 300) rb = ra / 16'd300 + 16'd1;
      run_div(ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
